seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
// Parametrised Wishbone-slave multiplexed 7-segment display controller for the user project area.
// Scans DIGITS common-anode/cathode digits from a register-held hex value, with per-digit decimal points,
// PWM brightness, per-digit blink and a frame-done interrupt. Outputs drive user IOs directly.
// PARAMETERS
// DIGITS         4    number of scanned digits, 1..8
// DIV_W          16   width of refresh prescaler register DIV
// PWM_W          4    brightness resolution; BRIGHT field is PWM_W+1 bits
// BLINK_SHIFT    5    blink phase toggles every 2**BLINK_SHIFT frames
// SEG_ACT_LOW    0    1: seg_o active-low
// DIG_ACT_LOW    0    1: digit_en_o active-low
// PORTS
// wb_clk_i    in   1       system clock
// wb_rst_ni   in   1       reset, asynchronous, active-low
// wbs_cyc_i   in   1       Wishbone cycle
// wbs_stb_i   in   1       Wishbone strobe
// wbs_we_i    in   1       write enable
// wbs_sel_i   in   4       byte lane selects (writes)
// wbs_adr_i   in   5       byte address; register index = wbs_adr_i[4:2]
// wbs_dat_i   in   32      write data
// wbs_dat_o   out  32      read data
// wbs_ack_o   out  1       transfer acknowledge
// seg_o       out  8      {dp,g,f,e,d,c,b,a}
// digit_en_o  out  DIGITS  one-hot digit select
// irq_o       out  1       level interrupt = STATUS.frame & CTRL.irq_en
// BEHAVIOUR
// - Reset (async, wb_rst_ni=0): all registers 0; wbs_ack_o=0; wbs_dat_o=0; irq_o=0; seg_o and
//   digit_en_o at inactive level (all 0, or all 1 when *_ACT_LOW=1); scan index=0; counters=0.
// - Registers: 0 CTRL[0]=en [1]=blink_en [2]=irq_en; 1 DATA: digit i = DATA[4i+3:4i];
//   2 DP[DIGITS-1:0]; 3 DIV[DIV_W-1:0]; 4 BRIGHT[PWM_W:0]; 5 BLINK mask[DIGITS-1:0];
//   6 STATUS[0]=frame (W1C), [15:8]=current scan index (RO). Unused bits/indices read 0, writes ignored.
// - Bus: cyc&stb&!ack -> ack=1 next cycle for exactly one cycle (1-cycle latency, no back-to-back ack).
//   Write commits on the ack edge, per byte lane by wbs_sel_i. Read data valid with ack, else 0.
// - Prescaler: when en, pre counts up each clock; when pre>=DIV: pre<=0, tick. Compare is >=, so
//   DIV lowered below pre ticks next cycle. DIV=0 -> tick every clock.
// - Scan: on tick idx<=idx+1, wrapping DIGITS-1 -> 0; wrap sets STATUS.frame and increments frame_cnt.
// - Blink phase = frame_cnt[BLINK_SHIFT]; frame_cnt wraps freely.
// - PWM: pwm_cnt (PWM_W bits) free-runs each clock when en; lit = (pwm_cnt < BRIGHT).
//   BRIGHT=0 always dark; BRIGHT>=2**PWM_W always lit.
// - Output (registered, 1-cycle after idx/pwm): digit_en_o active for idx iff en & lit &
//   !(blink_en & BLINK[idx] & phase); seg_o = {DP[idx], hexdec(DATA nibble idx)} when digit active,
//   else inactive. Hex decode standard: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71.
// - en=0: pre, idx, pwm_cnt, frame_cnt held at 0; outputs inactive next cycle; registers retain.
// - Frame set and W1C of STATUS.frame in same cycle: set wins.
// - DATA/DP/BLINK writes mid-scan take effect at next output register update (no tearing guard).
// TESTING
// 1 Reset: drive wb_rst_ni=0 mid-scan -> seg_o/digit_en_o inactive same cycle, all regs read 0.
// 2 DIGITS=4, DIV=3, BRIGHT=16, DATA=0x0000_1234, en=1 -> digit_en_o cycles 0001,0010,0100,1000
//   each for 4 clocks; seg_o = 0x66,0x4F,0x5B,0x06 respectively.
// 3 irq_en=1, after 16 clocks -> STATUS.frame=1, irq_o=1; write STATUS=1 -> clears; W1C on frame
//   cycle -> stays 1.
// 4 BRIGHT=4, PWM_W=4 -> digit active 4 of every 16 clocks; BRIGHT=0 -> never active.
// 5 BLINK=0b0010, blink_en=1, BLINK_SHIFT=1 -> digit 1 dark during frames 2-3, lit 0-1; DP=0b0001 -> seg_o[7]=1 on digit 0 only.
// 6 Bus: byte write sel=0010 to DATA=0xAABBCCDD -> only [15:8] updated; ack one cycle, then low;
//   DIV=100 then DIV=2 while pre=50 -> tick next cycle.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Wishbone-slave multiplexed 7-segment scanner: hex decode, per-digit DP, PWM brightness, blink, frame irq.
// Latency: bus ack one cycle after request; seg_o/digit_en_o registered one cycle after scan/PWM state.
// Backpressure: none; display free-runs, bus acks every request after one cycle and never back-to-back.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset; wbs_* Wishbone slave (byte address,
//   register index wbs_adr_i[4:2]); seg_o {dp,g,f,e,d,c,b,a}; digit_en_o one-hot digit select;
//   irq_o level interrupt = STATUS.frame & CTRL.irq_en.
module seven_seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DIV_W       = 16,
  parameter int PWM_W       = 4,
  parameter int BLINK_SHIFT = 5,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [4:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] digit_en_o,
  output logic              irq_o
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = {8{SEG_ACT_LOW != 0}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW != 0}};

  // Register file
  logic [2:0]         r_ctrl;
  logic [31:0]        r_data;
  logic [DIGITS-1:0]  r_dp;
  logic [DIV_W-1:0]   r_div;
  logic [PWM_W:0]     r_bright;
  logic [DIGITS-1:0]  r_blink;
  logic               r_frame;
  logic               r_ack;
  logic [31:0]        r_dat;

  // Scan state
  logic [DIV_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;
  logic [PWM_W-1:0]   r_pwm;
  logic [BLINK_SHIFT:0] r_fcnt;
  logic [7:0]         r_seg;
  logic [DIGITS-1:0]  r_dig;

  // Bus decode
  logic        w_req, w_wr;
  logic [2:0]  w_ridx;
  logic [31:0] w_wmask, w_rdat;
  logic        w_unused;

  assign w_req    = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr     = w_req & wbs_we_i;
  assign w_ridx   = wbs_adr_i[4:2];
  assign w_wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_unused = &{1'b0, wbs_adr_i[1:0]};

  // Byte-lane merged next values; narrow registers simply take the low lanes
  logic [2:0]        w_ctrl_nx;
  logic [31:0]       w_data_nx;
  logic [DIGITS-1:0] w_dp_nx, w_blink_nx;
  logic [DIV_W-1:0]  w_div_nx;
  logic [PWM_W:0]    w_bright_nx;

  assign w_ctrl_nx   = (r_ctrl & ~w_wmask[2:0]) | (wbs_dat_i[2:0] & w_wmask[2:0]);
  assign w_data_nx   = (r_data & ~w_wmask) | (wbs_dat_i & w_wmask);
  assign w_dp_nx     = (r_dp & ~w_wmask[DIGITS-1:0]) | (wbs_dat_i[DIGITS-1:0] & w_wmask[DIGITS-1:0]);
  assign w_blink_nx  = (r_blink & ~w_wmask[DIGITS-1:0]) | (wbs_dat_i[DIGITS-1:0] & w_wmask[DIGITS-1:0]);
  assign w_div_nx    = (r_div & ~w_wmask[DIV_W-1:0]) | (wbs_dat_i[DIV_W-1:0] & w_wmask[DIV_W-1:0]);
  assign w_bright_nx = (r_bright & ~w_wmask[PWM_W:0]) | (wbs_dat_i[PWM_W:0] & w_wmask[PWM_W:0]);

  always_comb begin
    w_rdat = '0;
    case (w_ridx)
      3'd0: w_rdat[2:0]        = r_ctrl;
      3'd1: w_rdat             = r_data;
      3'd2: w_rdat[DIGITS-1:0] = r_dp;
      3'd3: w_rdat[DIV_W-1:0]  = r_div;
      3'd4: w_rdat[PWM_W:0]    = r_bright;
      3'd5: w_rdat[DIGITS-1:0] = r_blink;
      3'd6: begin
        w_rdat[0]    = r_frame;
        w_rdat[15:8] = 8'(r_idx);
      end
      default: ;
    endcase
  end

  // Scan timing
  logic w_en, w_tick, w_wrap, w_frame_set, w_frame_clr;
  assign w_en        = r_ctrl[0];
  assign w_tick      = w_en & (r_pre >= r_div);  // >= so lowering DIV below pre ticks at once
  assign w_wrap      = (r_idx == IDX_W'(DIGITS - 1));
  assign w_frame_set = w_tick & w_wrap;
  assign w_frame_clr = w_wr & (w_ridx == 3'd6) & wbs_sel_i[0] & wbs_dat_i[0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ctrl   <= '0;
      r_data   <= '0;
      r_dp     <= '0;
      r_div    <= '0;
      r_bright <= '0;
      r_blink  <= '0;
      r_frame  <= 1'b0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~wbs_we_i) ? w_rdat : 32'd0;
      if (w_wr) begin
        case (w_ridx)
          3'd0: r_ctrl   <= w_ctrl_nx;
          3'd1: r_data   <= w_data_nx;
          3'd2: r_dp     <= w_dp_nx;
          3'd3: r_div    <= w_div_nx;
          3'd4: r_bright <= w_bright_nx;
          3'd5: r_blink  <= w_blink_nx;
          default: ;
        endcase
      end
      // A frame completing in the same cycle as a W1C keeps the flag set
      if (w_frame_set)      r_frame <= 1'b1;
      else if (w_frame_clr) r_frame <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_pwm  <= '0;
      r_fcnt <= '0;
    end else if (!w_en) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_pwm  <= '0;
      r_fcnt <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_W'(1);
      if (w_tick) begin
        r_pre <= '0;
        if (w_wrap) begin
          r_idx  <= '0;
          r_fcnt <= r_fcnt + (BLINK_SHIFT + 1)'(1);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_pre <= r_pre + DIV_W'(1);
      end
    end
  end

  // Output stage
  function automatic logic [6:0] hexdec(input logic [3:0] n);
    case (n)
      4'h0: hexdec = 7'h3F;  4'h1: hexdec = 7'h06;  4'h2: hexdec = 7'h5B;  4'h3: hexdec = 7'h4F;
      4'h4: hexdec = 7'h66;  4'h5: hexdec = 7'h6D;  4'h6: hexdec = 7'h7D;  4'h7: hexdec = 7'h07;
      4'h8: hexdec = 7'h7F;  4'h9: hexdec = 7'h6F;  4'hA: hexdec = 7'h77;  4'hB: hexdec = 7'h7C;
      4'hC: hexdec = 7'h39;  4'hD: hexdec = 7'h5E;  4'hE: hexdec = 7'h79;  default: hexdec = 7'h71;
    endcase
  endfunction

  logic [4:0]        w_nib_lsb;
  logic [3:0]        w_nib;
  logic              w_lit, w_phase, w_active;
  logic [DIGITS-1:0] w_onehot;

  assign w_nib_lsb = 5'({r_idx, 2'b00});
  assign w_nib     = r_data[w_nib_lsb +: 4];
  assign w_lit     = ({1'b0, r_pwm} < r_bright);
  assign w_phase   = r_fcnt[BLINK_SHIFT];
  assign w_active  = w_en & w_lit & ~(r_ctrl[1] & r_blink[r_idx] & w_phase);
  assign w_onehot  = DIGITS'(1) << r_idx;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_seg <= SEG_OFF;
      r_dig <= DIG_OFF;
    end else if (w_active) begin
      r_seg <= {r_dp[r_idx], hexdec(w_nib)} ^ SEG_OFF;
      r_dig <= w_onehot ^ DIG_OFF;
    end else begin
      r_seg <= SEG_OFF;
      r_dig <= DIG_OFF;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign seg_o      = r_seg;
  assign digit_en_o = r_dig;
  assign irq_o      = r_frame & r_ctrl[2];

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: stimulus pushes expected bus reads and display frames into queues,
// a negedge monitor pops and compares them; display expectations come from closed-form scan arithmetic.
// No backpressure involved; all waits are fixed cycle counts under a global watchdog.
module tb_seven_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int BLINK_SHIFT = 1;
  localparam logic [2:0] R_CTRL = 3'd0, R_DATA = 3'd1, R_DP = 3'd2, R_DIV = 3'd3,
                         R_BRIGHT = 3'd4, R_BLINK = 3'd5, R_STATUS = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [4:0]  adr = 5'h0;
  logic [31:0] dat_w = 32'h0;
  logic [31:0] dat_r;
  logic        ack, irq;
  logic [7:0]  seg;
  logic [DIGITS-1:0] dig;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .DIGITS(DIGITS), .DIV_W(16), .PWM_W(4), .BLINK_SHIFT(BLINK_SHIFT),
    .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_dat_o(dat_r), .wbs_ack_o(ack),
    .seg_o(seg), .digit_en_o(dig), .irq_o(irq)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] rd_q[$];
  logic [12:0] disp_q[$];   // {irq, seg[7:0], dig[3:0]}

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (disp_q.size() > 0) begin
        logic [12:0] e;
        e = disp_q.pop_front();
        total++;
        if ({irq, seg, dig} !== e) begin
          bad++;
          $display("FAIL display: got irq=%b seg=%h dig=%b want irq=%b seg=%h dig=%b",
                   irq, seg, dig, e[12], e[11:4], e[3:0]);
        end
      end
      if (ack && !we) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected: got %h want no read ack", dat_r);
        end else begin
          logic [31:0] e;
          e = rd_q.pop_front();
          if (dat_r !== e) begin
            bad++;
            $display("FAIL read_data adr=%h: got %h want %h", adr, dat_r, e);
          end
        end
      end
    end
  end

  // Every transfer takes two cycles so requests never sit behind an ack
  task automatic bus(input logic w, input logic [2:0] ri, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {ri, 2'b00}; dat_w = d; sel = s;
    @(posedge clk); #1;
    chk("ack_rise", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", {31'b0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] ri, input logic [31:0] d);
    bus(1'b1, ri, d, 4'hF);
  endtask

  task automatic rd(input logic [2:0] ri, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus(1'b0, ri, 32'h0, 4'h0);
  endtask

  // Expected display after the m-th clock edge following the enabling write
  function automatic logic [12:0] model(input int m, input int d, input int br, input logic [15:0] data,
                                        input logic [3:0] dp, input logic [3:0] bl,
                                        input logic ie, input logic be);
    int s, idx, frames;
    logic act, fr;
    logic [3:0] nib;
    logic [7:0] sg;
    logic [3:0] dg;
    s      = m - 1;
    idx    = (s / (d + 1)) % DIGITS;
    frames = s / ((d + 1) * DIGITS);
    act    = ((s % 16) < br) && !(be && bl[idx] && (((frames >> BLINK_SHIFT) & 1) == 1));
    nib    = data[idx*4 +: 4];
    sg     = act ? {dp[idx], hex_tab[nib]} : 8'h00;
    dg     = act ? 4'(1 << idx) : 4'h0;
    fr     = ie && (m >= (d + 1) * DIGITS);
    return {fr, sg, dg};
  endfunction

  task automatic window(input int d, input logic [31:0] br_raw, input logic [31:0] data,
                        input logic [31:0] dp_raw, input logic [31:0] bl_raw,
                        input logic ie, input logic be, input int len);
    wr(R_CTRL, 32'h0);
    wr(R_DIV, ($urandom & 32'hFFFF_0000) | 32'(d));
    wr(R_BRIGHT, br_raw);
    wr(R_DATA, data);
    wr(R_DP, dp_raw);
    wr(R_BLINK, bl_raw);
    wr(R_STATUS, 32'h1);
    wr(R_CTRL, {29'b0, ie, be, 1'b1});
    for (int m = 1; m <= len; m++) begin
      if (m > 1) begin
        @(posedge clk); #1;
      end
      disp_q.push_back(model(m, d, int'(br_raw & 32'h1F), data[15:0], dp_raw[3:0], bl_raw[3:0], ie, be));
    end
    wr(R_CTRL, 32'h0);
    rd(R_DIV, 32'(d));
    rd(R_BRIGHT, br_raw & 32'h1F);
    rd(R_STATUS, 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_seg", {24'b0, seg}, 32'h0);
    chk("rst_dig", {28'b0, dig}, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte lanes and masking of unimplemented bits
    wr(R_DATA, 32'h0000_1234);
    bus(1'b1, R_DATA, 32'hAABB_CCDD, 4'b0010);
    rd(R_DATA, 32'h0000_CC34);
    wr(R_DIV, 32'h0);
    bus(1'b1, R_DIV, 32'h1234_5678, 4'b0001);
    rd(R_DIV, 32'h0000_0078);
    bus(1'b1, R_DIV, 32'hFFFF_FFFF, 4'b1100);
    rd(R_DIV, 32'h0000_0078);

    // Held request: ack pulses, gaps, pulses again
    wr(R_CTRL, 32'hFFFF_FFF6);
    rd_q.push_back(32'h6);
    rd_q.push_back(32'h6);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {R_CTRL, 2'b00}; sel = 4'h0;
    @(posedge clk); #1; chk("ack_first", {31'b0, ack}, 32'd1);
    @(posedge clk); #1; chk("ack_gap",   {31'b0, ack}, 32'd0);
    @(posedge clk); #1; chk("ack_again", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1; chk("ack_idle",  {31'b0, ack}, 32'd0);

    // Directed scan windows
    window(3, 32'd16, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 64);
    window(3, 32'd4,  32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 64);
    window(3, 32'd0,  32'h0000_1234, 32'h0, 32'h0, 1'b1, 1'b0, 64);
    window(1, 32'd16, 32'h0000_1234, 32'h1, 32'h2, 1'b1, 1'b1, 80);

    // Random scan windows
    for (int w = 0; w < 5; w++) begin
      window(int'($urandom_range(0, 5)), 32'($urandom_range(0, 20)) | ($urandom & 32'hFFFF_FFE0),
             $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 120);
    end

    // Lowering DIV below the running prescaler ticks on the next clock
    wr(R_DATA, 32'h0000_1234);
    wr(R_DP, 32'h0);
    wr(R_BRIGHT, 32'd16);
    wr(R_DIV, 32'd100);
    wr(R_CTRL, 32'h1);
    repeat (48) @(posedge clk);
    #1;
    wr(R_DIV, 32'd2);
    disp_q.push_back({1'b0, 8'h66, 4'b0001});
    @(posedge clk); #1; disp_q.push_back({1'b0, 8'h4F, 4'b0010});
    @(posedge clk); #1; disp_q.push_back({1'b0, 8'h4F, 4'b0010});
    @(posedge clk); #1; disp_q.push_back({1'b0, 8'h4F, 4'b0010});
    @(posedge clk); #1; disp_q.push_back({1'b0, 8'h5B, 4'b0100});
    wr(R_CTRL, 32'h0);

    // Frame flag, irq, W1C racing a frame wrap, plain W1C
    wr(R_DIV, 32'd3);
    wr(R_STATUS, 32'h1);
    wr(R_CTRL, 32'h5);
    repeat (14) @(posedge clk);
    #1;
    chk("irq_before_frame", {31'b0, irq}, 32'd0);
    wr(R_STATUS, 32'h1);
    chk("irq_set_wins", {31'b0, irq}, 32'd1);
    rd(R_STATUS, 32'h0000_0001);
    wr(R_STATUS, 32'h1);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rd(R_STATUS, 32'h0000_0100);

    // Reset in the middle of a scan
    wr(R_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    #6 rst_n = 1'b0;
    #1;
    chk("midrst_seg", {24'b0, seg}, 32'h0);
    chk("midrst_dig", {28'b0, dig}, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    chk("midrst_ack", {31'b0, ack}, 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) rd(3'(r), 32'h0);
    for (int k = 0; k < 3; k++) begin
      disp_q.push_back(13'h0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("disp_queue_drained", 32'(disp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
